fp_wb_arbiter: RTL and testbench

- Write-side producer for the FP register file: collects completed results from NUM_SRC independent FP execution sources (FMA pipe, div/sqrt iterator, convert/move unit) with different latencies.
- Arbitrates round-robin and buffers results in a small in-order completion FIFO.
- Drives exactly one FP register write per cycle: enable, dest reg and data, which feed the regfile write port via the MA->WB struct.
- Honors pipeline stall so no result is lost or duplicated.

---
 rtl/fp_wb_arbiter.sv | 124 ++++++++++++
 tb/tb_fp_wb_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_wb_arbiter.sv
// Round-robin FP writeback arbiter: NUM_SRC result sources -> completion FIFO -> one regfile write per cycle.
// Optional macro FP_WB_BYPASS_EN: an empty, unstalled FIFO forwards the granted result combinationally.
module fp_wb_arbiter #(
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [NUM_SRC-1:0]              i_src_valid,
    output logic [NUM_SRC-1:0]              o_src_ready,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]   i_src_dest,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   i_src_data,
    input  logic                            i_stall,
    output logic                            o_wr_en,
    output logic [ADDR_WIDTH-1:0]           o_wr_dest,
    output logic [DATA_WIDTH-1:0]           o_wr_data,
    output logic [$clog2(FIFO_DEPTH):0]     o_pending,
    output logic                            o_full
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SRC_W = $clog2(NUM_SRC);

    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0] mem_dest_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];

    logic                  grant_found;
    logic [SRC_W-1:0]      grant_idx;
    logic [SRC_W-1:0]      cand;
    logic [ADDR_WIDTH-1:0] grant_dest;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;
    logic                  bypass;
    logic                  enq;
    logic                  deq;

    // First valid source at or after the round-robin pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = SRC_W'((32'(rr_ptr_q) + k) % NUM_SRC);
            if (!grant_found && i_src_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_dest = i_src_dest[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        grant_data = i_src_data[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        accept     = grant_found & ~fifo_full & i_rst_n;
`ifdef FP_WB_BYPASS_EN
        bypass     = accept & fifo_empty & ~i_stall;
`else
        bypass     = 1'b0;
`endif
        enq        = accept & ~bypass;
        deq        = ~fifo_empty & ~i_stall;

        o_src_ready = accept ? (NUM_SRC'(1) << grant_idx) : '0;

        wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
        end

        // Head of FIFO drives the write port; bypass only ever fires when empty.
        o_wr_en   = 1'b0;
        o_wr_dest = '0;
        o_wr_data = '0;
        if (bypass) begin
            o_wr_en   = 1'b1;
            o_wr_dest = grant_dest;
            o_wr_data = grant_data;
        end else if (!fifo_empty) begin
            o_wr_en   = 1'b1;
            o_wr_dest = mem_dest_q[rd_ptr_q];
            o_wr_data = mem_data_q[rd_ptr_q];
        end

        o_pending = count_q;
        o_full    = fifo_full;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge i_clk) begin
        if (enq) begin
            mem_dest_q[wr_ptr_q] <= grant_dest;
            mem_data_q[wr_ptr_q] <= grant_data;
        end
    end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Self-checking bench for fp_wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_fp_wb_arbiter;

    localparam int unsigned NS = 3;
    localparam int unsigned FD = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    typedef struct packed {
        logic [AW-1:0] d;
        logic [DW-1:0] v;
    } item_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NS-1:0]    src_valid;
    logic [NS-1:0]    src_ready;
    logic [NS*AW-1:0] src_dest;
    logic [NS*DW-1:0] src_data;
    logic             stall;
    logic             wr_en;
    logic [AW-1:0]    wr_dest;
    logic [DW-1:0]    wr_data;
    logic [2:0]       pending;
    logic             full;

    always #5 clk = ~clk;

    fp_wb_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(FD), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_src_valid(src_valid), .o_src_ready(src_ready),
        .i_src_dest(src_dest), .i_src_data(src_data),
        .i_stall(stall),
        .o_wr_en(wr_en), .o_wr_dest(wr_dest), .o_wr_data(wr_data),
        .o_pending(pending), .o_full(full)
    );

    int          errors = 0;
    int          checks = 0;
    item_t       srcq [NS][$];
    item_t       fifo_m [$];
    logic [NS-1:0] vld;
    int          rr;
    int          prob;
    bit          refill;
    int          mdl_commits = 0;
    int          dut_commits = 0;
    int          c0;
    logic [DW-1:0] dut_rf [32];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (refill && srcq[i].size() == 0 && $urandom_range(0, 3) == 0)
                srcq[i].push_back(item_t'({AW'($urandom), DW'($urandom)}));
            if (!vld[i] && srcq[i].size() > 0 && $urandom_range(0, 99) < prob)
                vld[i] = 1'b1;
            src_dest[i*AW +: AW] = vld[i] ? srcq[i][0].d : '0;
            src_data[i*DW +: DW] = vld[i] ? srcq[i][0].v : '0;
        end
        src_valid = vld;
    endtask

    // Model: grant = first valid from rr pointer; FIFO is a plain queue of accepted items.
    task automatic eval_cycle();
        int          g;
        logic [NS-1:0] er;
        bit          mfull;
        bit          acc;
        bit          byp;
        item_t       hd;
        mfull = (fifo_m.size() == FD);
        g = -1;
        for (int k = 0; k < NS; k++)
            if (g < 0 && vld[(rr + k) % NS]) g = (rr + k) % NS;
        acc = (g >= 0) && !mfull;
        er  = acc ? (NS'(1) << g) : '0;
        byp = 1'b0;
`ifdef FP_WB_BYPASS_EN
        byp = acc && fifo_m.size() == 0 && !stall;
`endif
        chk("ready", 64'(src_ready), 64'(er));
        if (byp) begin
            chk("wr_en", 64'(wr_en), 64'd1);
            chk("wr_dest", 64'(wr_dest), 64'(srcq[g][0].d));
            chk("wr_data", 64'(wr_data), 64'(srcq[g][0].v));
        end else if (fifo_m.size() > 0) begin
            chk("wr_en", 64'(wr_en), 64'd1);
            chk("wr_dest", 64'(wr_dest), 64'(fifo_m[0].d));
            chk("wr_data", 64'(wr_data), 64'(fifo_m[0].v));
        end else begin
            chk("wr_en", 64'(wr_en), 64'd0);
            chk("wr_dest", 64'(wr_dest), 64'd0);
            chk("wr_data", 64'(wr_data), 64'd0);
        end
        chk("pending", 64'(pending), 64'(fifo_m.size()));
        chk("full", 64'(full), 64'(mfull));

        if (wr_en && !stall) begin
            dut_commits++;
            dut_rf[wr_dest] = wr_data;
        end
        if (!byp && fifo_m.size() > 0 && !stall) begin
            void'(fifo_m.pop_front());
            mdl_commits++;
        end
        if (acc) begin
            hd = srcq[g].pop_front();
            vld[g] = 1'b0;
            rr = (g + 1) % NS;
            if (byp) mdl_commits++;
            else     fifo_m.push_back(hd);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            @(negedge clk);
            eval_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        vld = '1;
        src_valid = '1;
        src_dest = '0;
        src_data = '0;
        prob = 0;
        refill = 1'b0;
        rr = 0;
        for (int i = 0; i < 32; i++) dut_rf[i] = '0;
        #12;
        chk("rst_ready", 64'(src_ready), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_dest", 64'(wr_dest), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        vld = '0;
        src_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single result from source 0
        prob = 100;
        srcq[0].push_back('{5'd5, 32'h3F80_0000});
        run(3);

        // All three sources continuously valid
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < NS; i++) srcq[i].push_back('{AW'(i + 1), DW'(32'h100 * r + i)});
        run(16);

        // Stall fills the FIFO, release drains it while full-cycle dequeue blocks enqueue
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NS; i++) srcq[i].push_back('{AW'(10 + i), DW'($urandom)});
        stall = 1'b1;
        run(6);
        stall = 1'b0;
        run(12);

        // Two writes to the same register: later acceptance wins
        srcq[1].push_back('{5'd7, 32'hA});
        run(2);
        srcq[2].push_back('{5'd7, 32'hB});
        run(5);
        chk("waw_f7", 64'(dut_rf[7]), 64'hB);

        // Randomized traffic and stalls
        refill = 1'b1;
        prob = 50;
        repeat (400) begin
            stall = ($urandom_range(0, 9) < 3);
            run(1);
        end
        refill = 1'b0;
        stall = 1'b0;
        prob = 100;
        run(30);
        chk("commit_count", 64'(dut_commits), 64'(mdl_commits));

        // Asynchronous reset with three entries pending
        for (int i = 0; i < 3; i++) srcq[0].push_back('{AW'(20 + i), DW'($urandom)});
        stall = 1'b1;
        run(3);
        chk("pre_rst_pending", 64'(pending), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", 64'(wr_en), 64'd0);
        chk("async_rst_pending", 64'(pending), 64'd0);
        chk("async_rst_full", 64'(full), 64'd0);
        fifo_m.delete();
        for (int i = 0; i < NS; i++) srcq[i].delete();
        vld = '0;
        src_valid = '0;
        rr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        @(posedge clk);
        #1;
        c0 = dut_commits;
        run(5);
        chk("post_rst_commits", 64'(dut_commits - c0), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
